// File: rtl/instr_sequencer.sv
// instr_sequencer: program buffer that feeds a 16-bit core one word per completed instruction cycle.
module instr_sequencer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [15:0]       load_data,
  output logic              load_ready,
  input  logic              start,
  input  logic              step_mode,
  input  logic              step,
  input  logic [4:0]        tick,
  output logic [15:0]       instruction,
  output logic              cpu_enable,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W:0]   prog_len,
  output logic [1:0]        state
);
  typedef enum logic [1:0] {LOAD = 2'b00, RUN = 2'b01, PAUSE = 2'b10, HALT = 2'b11} state_t;
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d, pc_nx;
  logic [ADDR_W:0]     len_q, len_d;
  logic [15:0]         instr_q, instr_d, word0;
  logic                en_q, en_d, acc, fin, last;
  logic [15:0]         mem [DEPTH];
  assign load_ready  = state_q == LOAD && len_q < (ADDR_W+1)'(DEPTH);
  assign acc         = load_valid && load_ready;
  assign fin         = tick == 5'b10000;
  assign last        = {1'b0, pc_q} + 1'b1 == len_q;
  assign pc_nx       = pc_q + 1'b1;
  // a word accepted alongside start becomes slot 0 when the buffer was empty
  assign word0       = (acc && len_q == '0) ? load_data : mem[0];
  assign instruction = instr_q;
  assign cpu_enable  = en_q;
  assign pc          = pc_q;
  assign prog_len    = len_q;
  assign state       = state_q;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q + (ADDR_W+1)'(acc);
    instr_d = instr_q;
    en_d    = en_q;
    case (state_q)
      LOAD, HALT: if (start && len_d != '0) begin
        state_d = RUN;
        pc_d    = '0;
        instr_d = word0;
        en_d    = 1'b1;
      end
      RUN: if (fin) begin
        if (last) begin
          state_d = HALT;
          instr_d = '0;
          en_d    = 1'b0;
        end else begin
          pc_d    = pc_nx;
          instr_d = mem[pc_nx];
          state_d = step_mode ? PAUSE : RUN;
          en_d    = !step_mode;
        end
      end
      PAUSE: if (step || !step_mode) begin
        state_d = RUN;
        en_d    = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      pc_q    <= '0;
      len_q   <= '0;
      instr_q <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      instr_q <= instr_d;
      en_q    <= en_d;
    end
  end
  always_ff @(posedge clk)
    if (acc) mem[len_q[ADDR_W-1:0]] <= load_data;
endmodule
